// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with back-pressure and flush
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm_value,
    output logic [2:0]        imm_fmt,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ILL   = 3'd7;
    localparam int         LAST      = STAGES - 1;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [31:0]     dec_imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    // Every format fits in 32 bits sign-extended; widening to XLEN is a plain sign extension.
    always_comb begin
        dec_imm32 = '0;
        dec_fmt   = FMT_ILL;
        case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt   = FMT_SHAMT;
                    dec_imm32 = (XLEN == 64) ? {26'b0, instruction[25:20]}
                                             : {27'b0, instruction[24:20]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                end
            end
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {instruction[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_fmt   = FMT_NONE;
                dec_imm32 = '0;
            end
            default: begin
                dec_fmt   = FMT_ILL;
                dec_imm32 = '0;
            end
        endcase
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0][XLEN-1:0]  imm_q;
    logic [STAGES-1:0][2:0]       fmt_q;
    logic [STAGES:0]              ld;
    logic [STAGES-1:0]            src_v;
    logic [STAGES-1:0][XLEN-1:0]  src_imm;
    logic [STAGES-1:0][2:0]       src_fmt;

    // ld[k]: stage k may load this cycle; ld[STAGES] stands for the consumer.
    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end
    end

    assign in_ready = !flush && ld[0];

    always_comb begin
        src_v      = '0;
        src_imm    = '0;
        src_fmt    = '0;
        src_v[0]   = in_valid && in_ready;
        src_imm[0] = dec_imm;
        src_fmt[0] = dec_fmt;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_imm[k] = imm_q[k-1];
            src_fmt[k] = fmt_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            imm_q <= '0;
            fmt_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        imm_q[k] <= src_imm[k];
                        fmt_q[k] <= src_fmt[k];
                    end
                end
            end
        end
    end

    logic             deq;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Delivery still counts in a flush cycle, so the counter ignores flush.
    assign deq = v_q[LAST] && out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (deq && fmt_q[LAST] == FMT_ILL && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid     = v_q[LAST];
    assign imm_value     = imm_q[LAST];
    assign imm_fmt       = fmt_q[LAST];
    assign illegal       = (fmt_q[LAST] == FMT_ILL);
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = '0;

    logic        s1_in_ready, s1_out_valid, s1_illegal;
    logic [31:0] s1_imm;
    logic [2:0]  s1_fmt;
    logic [1:0]  s1_cnt;

    logic        s2_in_ready, s2_out_valid, s2_illegal;
    logic [31:0] s2_imm;
    logic [2:0]  s2_fmt;
    logic [15:0] s2_cnt;

    logic        s3_in_ready, s3_out_valid, s3_illegal;
    logic [31:0] s3_imm;
    logic [2:0]  s3_fmt;
    logic [15:0] s3_cnt;

    logic        w_in_ready, w_out_valid, w_illegal;
    logic [63:0] w_imm;
    logic [2:0]  w_fmt;
    logic [15:0] w_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .CNT_W(2)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
        .instruction(instruction), .out_valid(s1_out_valid), .out_ready(out_ready),
        .imm_value(s1_imm), .imm_fmt(s1_fmt), .illegal(s1_illegal), .illegal_count(s1_cnt));

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .CNT_W(16)) u_s2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s2_in_ready),
        .instruction(instruction), .out_valid(s2_out_valid), .out_ready(out_ready),
        .imm_value(s2_imm), .imm_fmt(s2_fmt), .illegal(s2_illegal), .illegal_count(s2_cnt));

    imm_gen_pipe #(.XLEN(32), .STAGES(3), .CNT_W(16)) u_s3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s3_in_ready),
        .instruction(instruction), .out_valid(s3_out_valid), .out_ready(out_ready),
        .imm_value(s3_imm), .imm_fmt(s3_fmt), .illegal(s3_illegal), .illegal_count(s3_cnt));

    imm_gen_pipe #(.XLEN(64), .STAGES(1), .CNT_W(16)) u_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .instruction(instruction), .out_valid(w_out_valid), .out_ready(out_ready),
        .imm_value(w_imm), .imm_fmt(w_fmt), .illegal(w_illegal), .illegal_count(w_cnt));

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send1(input logic [31:0] ins);
        @(negedge clk);
        instruction = ins; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic decode_chk(input string tag, input logic [31:0] ins, input logic [31:0] e32,
                              input logic [2:0] efmt, input logic [63:0] e64);
        send1(ins);
        expect_eq({tag, "_valid"}, s1_out_valid, 1'b1);
        expect_eq({tag, "_imm32"}, s1_imm, e32);
        expect_eq({tag, "_fmt"}, s1_fmt, efmt);
        expect_eq({tag, "_imm64"}, w_imm, e64);
    endtask

    logic [31:0] vec [4];
    int sent, recv, first_dq, last_dq;
    logic acc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        expect_eq("rst_out_valid", s1_out_valid, 1'b0);
        expect_eq("rst_imm", s1_imm, 32'h0);
        expect_eq("rst_fmt", s1_fmt, 3'd0);
        expect_eq("rst_illegal", s1_illegal, 1'b0);
        expect_eq("rst_cnt", s3_cnt, 16'h0);
        rst_n = 1'b1;
        #1;
        expect_eq("rst_in_ready", s3_in_ready, 1'b1);

        decode_chk("addi",  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF);
        decode_chk("sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC);
        decode_chk("lui",   32'h123452B7, 32'h12345000, 3'd4, 64'h0000000012345000);
        decode_chk("luineg",32'h800002B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000);
        decode_chk("beq",   32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC);
        decode_chk("jal",   32'h0080006F, 32'h00000008, 3'd5, 64'h0000000000000008);
        decode_chk("slli",  32'h00501093, 32'h00000005, 3'd6, 64'h0000000000000005);
        decode_chk("srai",  32'h40505093, 32'h00000005, 3'd6, 64'h0000000000000005);
        decode_chk("slli32",32'h02001093, 32'h00000000, 3'd6, 64'h0000000000000020);
        decode_chk("add",   32'h002081B3, 32'h00000000, 3'd0, 64'h0000000000000000);
        decode_chk("jalr",  32'h7FF00067, 32'h000007FF, 3'd1, 64'h00000000000007FF);
        decode_chk("ill",   32'h0000007F, 32'h00000000, 3'd7, 64'h0000000000000000);
        expect_eq("ill_flag", s1_illegal, 1'b1);

        // Illegal counter saturation
        do_reset();
        for (int i = 0; i < 5; i++) send1(32'h0000007F);
        repeat (3) @(negedge clk);
        expect_eq("cnt_sat_w2", s1_cnt, 2'd3);
        expect_eq("cnt_w16_s2", s2_cnt, 16'd5);
        expect_eq("cnt_w16_s3", s3_cnt, 16'd5);

        // Back-pressure on the 2-stage pipe
        do_reset();
        for (int k = 0; k < 4; k++) vec[k] = (32'(k + 1) << 20) | 32'h00000093;
        sent = 0; recv = 0; first_dq = -1; last_dq = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready   = (c >= 5);
            in_valid    = (sent < 4);
            instruction = vec[(sent < 4) ? sent : 3];
            #1;
            if (c == 4) begin
                expect_eq("bp_accepts", 64'(sent), 64'd2);
                expect_eq("bp_in_ready", s2_in_ready, 1'b0);
            end
            if (s2_out_valid && out_ready) begin
                expect_eq("bp_order", s2_imm, 64'(recv + 1));
                if (first_dq < 0) first_dq = c;
                last_dq = c;
                recv++;
            end
            acc = in_valid && s2_in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        expect_eq("bp_recv", 64'(recv), 64'd4);
        expect_eq("bp_first", 64'(first_dq), 64'd5);
        expect_eq("bp_nogap", 64'(last_dq - first_dq), 64'd3);

        // Flush of a full 3-stage pipe, then asynchronous reset mid-stream
        do_reset();
        @(negedge clk);
        instruction = 32'h0000007F; in_valid = 1'b1; out_ready = 1'b0;
        repeat (4) @(negedge clk);
        expect_eq("fl_full_valid", s3_out_valid, 1'b1);
        expect_eq("fl_full_ready", s3_in_ready, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        expect_eq("fl_in_ready", s3_in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        expect_eq("fl_out_valid", s3_out_valid, 1'b0);
        expect_eq("fl_cnt", s3_cnt, 16'd1);
        #1;
        expect_eq("fl_ready_after", s3_in_ready, 1'b1);
        repeat (6) @(negedge clk);
        expect_eq("ar_valid_before", s3_out_valid, 1'b1);
        expect_eq("ar_cnt_nonzero", 64'(s3_cnt != 16'd0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq("ar_out_valid", s3_out_valid, 1'b0);
        expect_eq("ar_cnt", s3_cnt, 16'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
